mips_register_file: RTL and testbench
=====================================

Name: mips_register_file

Overview:
- 8-entry x 32-bit general-purpose register file for the single-cycle MIPS datapath.
- Sits directly upstream of the ALU and supplies both operand buses (rs, rt) that feed the ALU's bitwise OR/AND/ADD slices.
- Has one synchronous write port, driven by the writeback mux.
- Register 0 is hardwired to zero.

Parameters:
- DATA_W, 32, register width in bits; must match the ALU operand width.
- ADDR_W, 3, register index width; the file holds 2**ADDR_W entries.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- read_reg1  input  ADDR_W  index of operand A (rs).
- read_reg2  input  ADDR_W  index of operand B (rt).
- read_data1  output  DATA_W  contents of read_reg1, to ALU input A.
- read_data2  output  DATA_W  contents of read_reg2, to ALU input B / immediate mux.
- write_en  input  1  RegWrite control; high commits write_data on the next rising edge.
- write_reg  input  ADDR_W  destination index (rd or rt, selected upstream).
- write_data  input  DATA_W  writeback value (ALU result or memory data).

Behaviour:
- Storage: registers r1..r7 are edge-triggered. r0 has no storage and always reads 0.
- Reset:
  - rst_n is sampled low at a rising edge: r1..r7 are all cleared to 0 at that edge.
  - A write presented in the same cycle is discarded; reset has priority over write_en.
  - With rst_n low, both read outputs follow the combinational read rules below. Since stored contents are 0 after the first reset edge, both outputs read 0 unless a bypass applies.
  - Bypass is suppressed while rst_n is low, so both outputs are 0 from the first reset edge onward.
- Write:
  - Condition: rising edge of clk, rst_n high, write_en high, and write_reg != 0.
  - Effect: r[write_reg] <= write_data.
  - A write to index 0 is ignored and r0 stays 0.
  - write_en low leaves all registers unchanged.
- Read:
  - Both ports are fully combinational (zero-cycle latency) and independent.
  - Each port can address any index, including the same index as the other port.
  - Either port addressing index 0 outputs 0 regardless of any write in flight.
- Write-to-read bypass:
  - Applies when write_en=1, rst_n=1, write_reg != 0, and write_reg equals a port's read index.
  - That port outputs write_data in the same cycle, before the edge, so a single-cycle consumer sees the new value.
  - Both ports bypass simultaneously if both match.
- Simultaneous events:
  - A read and a write to the same index in the same cycle return the bypassed write_data.
  - After the edge, the stored value equals that same write_data, so there is no glitch between cycles.
- Arithmetic/width:
  - No arithmetic; data is passed bit-exact across all DATA_W bits.
  - Index comparisons use all ADDR_W bits.
- Reset mid-operation: a reset edge arriving between writes clears all prior contents. The next write after rst_n returns high behaves normally.
- Implementation style:
  - Structural build from the team's gate-level primitives: a 3-to-8 write decoder gated by write_en, per-register enable flops, two 8:1 32-bit read muxes, and a bypass comparator.
  - Behavioural storage for the flops is permitted.

Test Plan:
- Reset clear: write r1..r7 = 32'h1111_1111..32'h7777_7777, pulse rst_n low one edge, then read r1..r7 on both ports -> every read is 32'h0000_0000.
- Basic write/read: write r3=32'hDEAD_BEEF, write r5=32'h0000_FFFF; next cycle read_reg1=3, read_reg2=5 -> read_data1=32'hDEAD_BEEF, read_data2=32'h0000_FFFF. A subsequent OR of these through the ALU yields 32'hDEAD_FFFF.
- r0 hardwired: write_en=1, write_reg=0, write_data=32'hFFFF_FFFF; read_reg1=0 same cycle and next cycle -> read_data1=0 both cycles.
- Bypass: r2 holds 32'h0000_0001; drive write_en=1, write_reg=2, write_data=32'hA5A5_A5A5 with read_reg1=read_reg2=2 -> both outputs show 32'hA5A5_A5A5 before the edge and remain so after it.
- write_en low: r4=32'h1234_5678; present write_reg=4, write_data=32'h0, write_en=0 for 3 edges -> r4 still reads 32'h1234_5678.
- Reset vs write same edge: rst_n=0 with write_en=1, write_reg=6, write_data=32'hCAFE_F00D -> after the edge r6 reads 0; during that cycle read_data for index 6 is 0 (bypass suppressed).

Source files
------------

// File: rtl/mips_register_file.sv
// Eight-entry general-purpose register file for the single-cycle MIPS datapath.
// Two combinational read ports with same-cycle write bypass; r0 is hardwired to zero.
module mips_register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data
);

  localparam int NREG = 1 << ADDR_W;

  // Read-side view of the array; entry 0 has no storage behind it.
  logic [DATA_W-1:0] rd_array [NREG];

  assign rd_array[0] = '0;

  genvar g;
  generate
    for (g = 1; g < NREG; g++) begin : g_reg
      logic              we;
      logic [DATA_W-1:0] q;

      // Write decoder output for this entry, gated by write_en.
      assign we = write_en && (write_reg == ADDR_W'(g));

      // NOTE: every stored entry is a real flop with a synchronous clear, so a
      // reset edge wipes the whole file; this is not a RAM macro.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          q <= '0;
        end else if (we) begin
          q <= write_data;
        end
      end

      assign rd_array[g] = q;
    end
  endgenerate

  logic              wr_live;
  logic              byp1;
  logic              byp2;
  logic [DATA_W-1:0] stored1;
  logic [DATA_W-1:0] stored2;

  assign stored1 = rd_array[read_reg1];
  assign stored2 = rd_array[read_reg2];

  // Bypass only for a write that will actually commit at the coming edge.
  assign wr_live = rst_n && write_en && (write_reg != '0);
  assign byp1    = wr_live && (write_reg == read_reg1);
  assign byp2    = wr_live && (write_reg == read_reg2);

  assign read_data1 = byp1 ? write_data : stored1;
  assign read_data2 = byp2 ? write_data : stored2;

endmodule

// File: tb/tb_mips_register_file.sv
// Directed-vector bench for mips_register_file: stimulus pushes expected read
// values into a queue, a monitor pops and compares them mid-cycle.
module tb_mips_register_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  read_reg1;
  logic [2:0]  read_reg2;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic        write_en;
  logic [2:0]  write_reg;
  logic [31:0] write_data;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  mips_register_file #(.DATA_W(32), .ADDR_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .write_en   (write_en),
    .write_reg  (write_reg),
    .write_data (write_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic we, input logic [2:0] wr,
                       input logic [31:0] wd, input logic [2:0] r1, input logic [2:0] r2);
    rst_n      = rst;
    write_en   = we;
    write_reg  = wr;
    write_data = wd;
    read_reg1  = r1;
    read_reg2  = r2;
  endtask

  task automatic expect_rd(input string name, input logic [31:0] e1, input logic [31:0] e2);
    exp_t e;
    e.name = name;
    e.e1   = e1;
    e.e2   = e2;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: the outputs are combinational, so mid-cycle is a stable sample point.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, ".rd1"}, read_data1, e.e1);
        check({e.name, ".rd2"}, read_data2, e.e2);
      end
    end
  end

  initial begin
    drive(1'b0, 1'b0, 3'd0, 32'h0, 3'd0, 3'd0);
    tick();
    tick();

    // Reset state
    drive(1'b1, 1'b0, 3'd0, 32'h0, 3'd1, 3'd7);
    expect_rd("reset_state", 32'h0, 32'h0);
    tick();

    // Fill r1..r7 with 0x11111111 * i
    for (int i = 1; i < 8; i++) begin
      drive(1'b1, 1'b1, 3'(i), 32'h1111_1111 * i, 3'd0, 3'd0);
      tick();
    end
    drive(1'b1, 1'b0, 3'd0, 32'h0, 3'd1, 3'd7);
    expect_rd("fill_readback", 32'h1111_1111, 32'h7777_7777);
    tick();

    // One reset edge clears everything
    drive(1'b0, 1'b0, 3'd0, 32'h0, 3'd0, 3'd0);
    tick();
    for (int i = 1; i < 8; i++) begin
      drive(1'b1, 1'b0, 3'd0, 32'h0, 3'(i), 3'(i));
      expect_rd($sformatf("reset_clear_r%0d", i), 32'h0, 32'h0);
      tick();
    end

    // Basic write/read
    drive(1'b1, 1'b1, 3'd3, 32'hDEAD_BEEF, 3'd0, 3'd0);
    tick();
    drive(1'b1, 1'b1, 3'd5, 32'h0000_FFFF, 3'd0, 3'd0);
    tick();
    drive(1'b1, 1'b0, 3'd0, 32'h0, 3'd3, 3'd5);
    expect_rd("basic_rw", 32'hDEAD_BEEF, 32'h0000_FFFF);
    tick();

    // r0 hardwired: same cycle as the write and the cycle after
    drive(1'b1, 1'b1, 3'd0, 32'hFFFF_FFFF, 3'd0, 3'd0);
    expect_rd("r0_write_cycle", 32'h0, 32'h0);
    tick();
    drive(1'b1, 1'b0, 3'd0, 32'h0, 3'd0, 3'd0);
    expect_rd("r0_after", 32'h0, 32'h0);
    tick();

    // Bypass on both ports
    drive(1'b1, 1'b1, 3'd2, 32'h0000_0001, 3'd0, 3'd0);
    tick();
    drive(1'b1, 1'b0, 3'd0, 32'h0, 3'd2, 3'd2);
    expect_rd("r2_old", 32'h0000_0001, 32'h0000_0001);
    tick();
    drive(1'b1, 1'b1, 3'd2, 32'hA5A5_A5A5, 3'd2, 3'd2);
    expect_rd("bypass_both", 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    tick();
    drive(1'b1, 1'b0, 3'd2, 32'h0, 3'd2, 3'd2);
    expect_rd("bypass_after", 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    tick();

    // Bypass on one port only, other port reads storage
    drive(1'b1, 1'b1, 3'd3, 32'h0000_0033, 3'd3, 3'd5);
    expect_rd("bypass_one", 32'h0000_0033, 32'h0000_FFFF);
    tick();

    // write_en low for three edges
    drive(1'b1, 1'b1, 3'd4, 32'h1234_5678, 3'd0, 3'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 3'd4, 32'h0, 3'd4, 3'd4);
      expect_rd($sformatf("we_low_%0d", i), 32'h1234_5678, 32'h1234_5678);
      tick();
    end
    drive(1'b1, 1'b0, 3'd0, 32'h0, 3'd4, 3'd3);
    expect_rd("we_low_final", 32'h1234_5678, 32'h0000_0033);
    tick();

    // Full-width, all index bits
    drive(1'b1, 1'b1, 3'd7, 32'h8000_0001, 3'd0, 3'd0);
    tick();
    drive(1'b1, 1'b0, 3'd0, 32'h0, 3'd6, 3'd7);
    expect_rd("r7_width", 32'h0, 32'h8000_0001);
    tick();

    // Reset versus write at the same edge; r6 holds 0 so the read is determined
    drive(1'b0, 1'b1, 3'd6, 32'hCAFE_F00D, 3'd6, 3'd6);
    expect_rd("rst_wr_cycle", 32'h0, 32'h0);
    tick();
    drive(1'b1, 1'b0, 3'd0, 32'h0, 3'd6, 3'd4);
    expect_rd("rst_wr_after", 32'h0, 32'h0);
    tick();

    // Normal write after reset release
    drive(1'b1, 1'b1, 3'd6, 32'hCAFE_F00D, 3'd0, 3'd0);
    tick();
    drive(1'b1, 1'b0, 3'd0, 32'h0, 3'd6, 3'd2);
    expect_rd("post_reset_wr", 32'hCAFE_F00D, 32'h0);
    tick();

    drive(1'b1, 1'b0, 3'd0, 32'h0, 3'd0, 3'd0);
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) tick();
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
